// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the NTT engine.
// All arithmetic parameters live here so the core and butterfly agree on them.
package ntt_pkg;

  localparam int N     = 8;
  localparam int LOGN  = $clog2(N);
  localparam int DW    = 8;
  localparam int Q     = 17;
  localparam int OMEGA = 2;
  localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [N/2-1:0][DW-1:0] tw_t;

  function automatic int pow_mod(input int base, input int exp, input int q);
    int r;
    r = 1;
    for (int k = 0; k < exp; k++) r = (r * base) % q;
    return r;
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx, input int bits);
    logic [LOGN-1:0] r;
    r = '0;
    for (int k = 0; k < LOGN; k++)
      if (k < bits) r[k] = idx[bits-1-k];
    return r;
  endfunction

  function automatic tw_t gen_tw();
    tw_t t;
    for (int i = 0; i < N/2; i++) t[i] = DW'(pow_mod(OMEGA, i, Q));
    return t;
  endfunction

  // TW[i] = OMEGA^i mod Q, fixed at elaboration.
  localparam tw_t TW = gen_tw();

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational Cooley-Tukey butterfly: (a, b, w) -> (a + w*b, a - w*b) mod Q.
// Inputs are assumed already reduced below Q.
module ntt_butterfly
  import ntt_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] a_next,
  output logic [DW-1:0] b_next
);

  localparam logic [2*DW-1:0] QP = (2*DW)'(Q);
  localparam logic [DW:0]     QX = (DW+1)'(Q);

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   t;
  logic [DW:0]     sum;
  logic [DW:0]     diff;

  always_comb begin
    prod = w * b;
    t    = DW'(prod % QP);
    // Both sums stay below 2Q, so one conditional subtract fully reduces them.
    sum  = {1'b0, a} + {1'b0, t};
    diff = {1'b0, a} + QX - {1'b0, t};
    a_next = (sum  >= QX) ? DW'(sum  - QX) : sum[DW-1:0];
    b_next = (diff >= QX) ? DW'(diff - QX) : diff[DW-1:0];
  end

endmodule

// File: rtl/ntt_core.sv
// Iterative in-place radix-2 DIT forward NTT: bit-reversed load, one shared
// butterfly per cycle, natural-order result on out with a one-cycle done pulse.
module ntt_core
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          WriteIn,
  input  logic          Ntt,
  input  logic [DW-1:0] in [N],
  output logic [DW-1:0] out [N],
  output logic          busy,
  output logic          done
);

  localparam logic [SW-1:0]   S_LAST = SW'(LOGN-1);
  localparam logic [LOGN-2:0] B_LAST = (LOGN-1)'(N/2-1);
  localparam logic [DW-1:0]   QD     = DW'(Q);

  state_t          state, state_d;
  logic [SW-1:0]   s_q;
  logic [LOGN-2:0] b_q;
  logic [DW-1:0]   work_buf [N];

  logic [LOGN-1:0] half, bx, j, top, bot;
  logic [LOGN-2:0] tw_idx;
  logic            last;
  logic [DW-1:0]   a_next, b_next;

  // Butterfly addressing for stage s_q, butterfly b_q.
  always_comb begin
    half   = LOGN'(1) << s_q;
    bx     = {1'b0, b_q};
    j      = bx & (half - LOGN'(1));
    top    = ((bx >> s_q) << (s_q + SW'(1))) + j;
    bot    = top + half;
    tw_idx = (LOGN-1)'(j << (S_LAST - s_q));
    last   = (s_q == S_LAST) && (b_q == B_LAST);
  end

  ntt_butterfly u_bfly (
    .a      (work_buf[top]),
    .b      (work_buf[bot]),
    .w      (TW[tw_idx]),
    .a_next (a_next),
    .b_next (b_next)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (!WriteIn && Ntt) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i < N; i++) work_buf[i] <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (WriteIn) begin
            for (int i = 0; i < N; i++)
              work_buf[bitrev(LOGN'(i), LOGN)] <= in[i] % QD;
          end else if (Ntt) begin
            s_q <= '0;
            b_q <= '0;
          end
        end
        RUN: begin
          work_buf[top] <= a_next;
          work_buf[bot] <= b_next;
          if (b_q == B_LAST) begin
            b_q <= '0;
            s_q <= s_q + SW'(1);
          end else begin
            b_q <= b_q + (LOGN-1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) out[i] = work_buf[i];
  end

endmodule

// File: tb/tb_ntt_core.sv
// Directed bench for ntt_core: hand-computed NTT vectors, load/start priority,
// busy lockout and reset abandonment, checked through a scoreboard queue.
module tb_ntt_core;

  localparam int N = 8;
  localparam int W = 8;

  typedef logic [W-1:0] vec_t [N];

  logic       clk = 1'b0;
  logic       rst;
  logic       write_in;
  logic       ntt_go;
  vec_t       din;
  vec_t       dout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ntt_core dut (
    .clk     (clk),
    .rst     (rst),
    .WriteIn (write_in),
    .Ntt     (ntt_go),
    .in      (din),
    .out     (dout),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input vec_t e);
    for (int i = 0; i < N; i++) exp_q.push_back(e[i]);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, " queue"}, 32'd1, 32'd0);
      end else begin
        check($sformatf("%s[%0d]", tag, i), 32'(dout[i]), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic load_vec(input vec_t v);
    @(negedge clk);
    din      = v;
    write_in = 1'b1;
    @(negedge clk);
    write_in = 1'b0;
  endtask

  // Starts a transform and waits for done; if disturb > 0, drives a load of
  // alt at that cycle of the run, which must be ignored.
  task automatic run_ntt(input string tag, input int disturb, input vec_t alt);
    int cycles;
    @(negedge clk);
    ntt_go = 1'b1;
    @(negedge clk);
    ntt_go = 1'b0;
    check({tag, " busy_start"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < 40) begin
      if (disturb > 0 && cycles == disturb) begin
        din      = alt;
        write_in = 1'b1;
      end else begin
        write_in = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    write_in = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'd12);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check_out(tag);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  vec_t v_imp, v_ones, v_shift, v_red, v_mix, v_zero;
  vec_t e_ones, e_dc, e_shift, e_mix, e_red_load;
  int   seen_done;

  initial begin
    v_imp      = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_ones     = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    v_shift    = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_red      = '{8'd18, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_mix      = '{8'd3, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_zero     = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_ones     = v_ones;
    e_dc       = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_shift    = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
    e_mix      = '{8'd8, 8'd13, 8'd6, 8'd9, 8'd15, 8'd10, 8'd0, 8'd14};
    e_red_load = v_imp;

    rst      = 1'b1;
    write_in = 1'b0;
    ntt_go   = 1'b0;
    din      = v_zero;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    push_exp(v_zero);
    check_out("reset out");

    // Transform of the zero buffer left by reset.
    push_exp(v_zero);
    run_ntt("zero", 0, v_zero);

    load_vec(v_imp);
    push_exp(e_ones);
    run_ntt("impulse", 0, v_zero);

    load_vec(v_ones);
    push_exp(e_dc);
    run_ntt("all_ones", 0, v_zero);

    load_vec(v_shift);
    push_exp(e_shift);
    run_ntt("shift", 0, v_zero);

    load_vec(v_mix);
    push_exp(e_mix);
    run_ntt("mix", 0, v_zero);

    // Load and start together: load wins, 18 reduces to 1, no transform.
    @(negedge clk);
    din      = v_red;
    write_in = 1'b1;
    ntt_go   = 1'b1;
    @(negedge clk);
    write_in = 1'b0;
    ntt_go   = 1'b0;
    check("prio busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("prio still idle", 32'(busy | done), 32'd0);
    push_exp(e_red_load);
    check_out("prio load");
    push_exp(e_ones);
    run_ntt("reduce", 0, v_zero);

    // Mid-run load attempt is ignored.
    load_vec(v_shift);
    push_exp(e_shift);
    run_ntt("lockout", 4, v_ones);

    // Reset after five butterflies abandons the run.
    load_vec(v_shift);
    @(negedge clk);
    ntt_go = 1'b1;
    @(negedge clk);
    ntt_go = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    push_exp(v_zero);
    check_out("rst_mid out");
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst_mid no_done", 32'(seen_done), 32'd0);

    load_vec(v_mix);
    push_exp(e_mix);
    run_ntt("after_rst", 0, v_zero);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
